cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Multi-cycle control sequencer for the 18-bit CPU datapath: owns the 10-bit program counter, instruction register and condition flags. It steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB, and drives the ALU, register file and data memory enables. It replaces the single-cycle control unit and free-running PC. Data memory accesses use a req/ack handshake, so memory may stall the core for any number of cycles.

## Interface
Parameters:
- PC_RESET, 10'd0, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- run  in  1  when 0, sequencer holds in FETCH (no fetch, no PC increment)
- instr  in  18  instruction memory data at address pc (combinational memory)
- alu_zero  in  1  ALU zero flag, valid during EXECUTE
- alu_carry  in  1  ALU carry-out, valid during EXECUTE
- mem_ack  in  1  data memory completion; sampled only in MEM
- pc  out  10  program counter / instruction memory address
- ir  out  18  latched instruction; field decode downstream uses this, not instr
- alu_op  out  3  ALU control
- alu_src  out  1  1 = zero-extended imm (ir[5:0]) as operand B
- reg_write  out  1  register file write enable
- mem_to_reg  out  1  write-back source = data memory
- mem_req  out  1  data memory request
- mem_we  out  1  1 = store, qualifies mem_req
- zf, cf  out  1 each  registered flags
- halted  out  1  sequencer in HALT
- state  out  3  FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALT=5
- retired  out  16  retired-instruction count, wraps 65535 -> 0

## Operation
Opcode = ir[17:14]:
- 0x0–0x7: ALU ops. alu_op = {1'b0, ir[16:15]}; alu_src = ir[14].
- 0x8: LD
- 0x9: ST
- 0xA: JMP
- 0xB: BEQ (taken if zf)
- 0xC: BNE (taken if !zf)
- 0xD: BCS (taken if cf)
- 0xE: NOP
- 0xF: HALT

Branch and jump target = ir[9:0], absolute.

State sequence:
- FETCH: if run, ir <= instr, pc <= pc+1 (1023 wraps to 0), -> DECODE. Otherwise hold.
- DECODE: one cycle, no enables. HALT opcode -> HALT; all others -> EXECUTE.
- EXECUTE:
  - ALU ops: zf <= alu_zero, cf <= alu_carry, -> WB.
  - LD/ST: -> MEM.
  - JMP or taken branch: pc <= ir[9:0], -> FETCH.
  - Untaken branch and NOP: -> FETCH.
  - Flags change only on ALU ops.
- MEM: mem_req = 1; mem_we = 1 for ST only. Hold until mem_ack = 1. On ack: LD -> WB, ST -> FETCH.
- WB: reg_write = 1 for exactly this cycle; mem_to_reg = 1 for LD. -> FETCH.
- HALT: absorbing state; only reset exits. halted = 1.

Output decode:
- alu_op and alu_src are driven from ir in EXECUTE and WB; 0 elsewhere.
- mem_req, mem_we, reg_write and mem_to_reg are 0 outside the states named above.

Retired counter:
- Increments by 1 on the final cycle of each instruction: WB; MEM on ack for ST; EXECUTE for JMP, branch or NOP.
- HALT is not counted.

Reset (any state, including mid-MEM): state = FETCH, pc = PC_RESET, ir = 0, zf = cf = 0, retired = 0, all enables 0, halted = 0. An outstanding memory request is abandoned. mem_ack arriving after reset is ignored.

## Timing
Cycles per instruction, with run = 1 and ack in the first MEM cycle:
- ALU: 4
- LD: 5
- ST: 4
- JMP, branch, NOP: 3
- HALT: 2 cycles to enter HALT

Each extra cycle mem_ack stays low adds one MEM cycle. mem_req stays high continuously until the ack cycle and drops the next cycle.

Other rules:
- pc changes only at the end of FETCH or of a taken EXECUTE, never both for the same instruction.
- Flags written in EXECUTE are visible to the next instruction's EXECUTE, so back-to-back ALU then BEQ works with no hazard.
- run low while in DECODE through WB has no effect; it gates FETCH only.

## Test plan
- Reset then run = 1, memory with NOP at 0 and 1 → pc 0→1→2, state 0,1,2,0,1,2, retired = 2 after 6 cycles.
- ALU op 0x1 (ADDI) with alu_zero = 1 → alu_src = 1, alu_op = 0 in EXECUTE; zf = 1 after EXECUTE; reg_write high exactly one cycle (cycle 4); then BEQ target 0x155 → pc = 0x155.
- LD with mem_ack delayed 3 cycles → mem_req high 4 cycles, mem_we = 0, WB with mem_to_reg = 1, total 8 cycles, retired += 1.
- ST with immediate ack → mem_req = mem_we = 1 for one cycle, no reg_write, 4 cycles.
- pc = 1023 fetching NOP → pc wraps to 0. HALT opcode → halted = 1 and pc frozen for 20 cycles; reset → pc = 0, halted = 0.
- Reset asserted mid-MEM with mem_ack low → next cycle state = FETCH, mem_req = 0, retired = 0; a later stray mem_ack causes no effect.

Source files
------------

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle FETCH/DECODE/EXECUTE/MEM/WB control sequencer for the 18-bit CPU
module cpu_sequencer #(
    parameter logic [9:0] PC_RESET = 10'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [17:0] instr,
    input  logic        alu_zero,
    input  logic        alu_carry,
    input  logic        mem_ack,
    output logic [9:0]  pc,
    output logic [17:0] ir,
    output logic [2:0]  alu_op,
    output logic        alu_src,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        mem_req,
    output logic        mem_we,
    output logic        zf,
    output logic        cf,
    output logic        halted,
    output logic [2:0]  state,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_BEQ  = 4'hB;
    localparam logic [3:0] OP_BNE  = 4'hC;
    localparam logic [3:0] OP_BCS  = 4'hD;
    localparam logic [3:0] OP_NOP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t      cur;
    state_t      nxt;
    logic [9:0]  pc_nxt;
    logic [17:0] ir_nxt;
    logic        retire;
    logic        alu_instr;
    logic [3:0]  opcode;
    logic [3:0]  opcode_nxt;

    assign opcode     = ir[17:14];
    assign opcode_nxt = ir_nxt[17:14];
    assign alu_instr  = ~opcode[3];
    assign state      = cur;

    always_comb begin
        nxt    = cur;
        pc_nxt = pc;
        ir_nxt = ir;
        retire = 1'b0;
        case (cur)
            S_FETCH: begin
                if (run) begin
                    ir_nxt = instr;
                    pc_nxt = pc + 10'd1;
                    nxt    = S_DECODE;
                end
            end
            S_DECODE: begin
                nxt = (opcode == OP_HALT) ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
                if (alu_instr) begin
                    nxt = S_WB;
                end else begin
                    case (opcode)
                        OP_LD, OP_ST: nxt = S_MEM;
                        OP_JMP: begin
                            pc_nxt = ir[9:0];
                            nxt    = S_FETCH;
                            retire = 1'b1;
                        end
                        OP_BEQ, OP_BNE, OP_BCS: begin
                            if ((opcode == OP_BEQ && zf) || (opcode == OP_BNE && !zf) ||
                                (opcode == OP_BCS && cf))
                                pc_nxt = ir[9:0];
                            nxt    = S_FETCH;
                            retire = 1'b1;
                        end
                        OP_NOP: begin
                            nxt    = S_FETCH;
                            retire = 1'b1;
                        end
                        default: nxt = S_HALT;
                    endcase
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    nxt    = (opcode == OP_ST) ? S_FETCH : S_WB;
                    retire = (opcode == OP_ST);
                end
            end
            S_WB: begin
                nxt    = S_FETCH;
                retire = 1'b1;
            end
            default: nxt = S_HALT;
        endcase
    end

    // Outputs are decoded from the upcoming state so they line up with it as registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur        <= S_FETCH;
            pc         <= PC_RESET;
            ir         <= 18'd0;
            zf         <= 1'b0;
            cf         <= 1'b0;
            retired    <= 16'd0;
            alu_op     <= 3'd0;
            alu_src    <= 1'b0;
            reg_write  <= 1'b0;
            mem_to_reg <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            halted     <= 1'b0;
        end else begin
            cur     <= nxt;
            pc      <= pc_nxt;
            ir      <= ir_nxt;
            retired <= retired + {15'd0, retire};
            if (cur == S_EXECUTE && alu_instr) begin
                zf <= alu_zero;
                cf <= alu_carry;
            end
            alu_op     <= (nxt == S_EXECUTE || nxt == S_WB) ? {1'b0, ir_nxt[16:15]} : 3'd0;
            alu_src    <= (nxt == S_EXECUTE || nxt == S_WB) ? ir_nxt[14] : 1'b0;
            reg_write  <= (nxt == S_WB);
            mem_to_reg <= (nxt == S_WB) && (opcode_nxt == OP_LD);
            mem_req    <= (nxt == S_MEM);
            mem_we     <= (nxt == S_MEM) && (opcode_nxt == OP_ST);
            halted     <= (nxt == S_HALT);
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed self-checking bench for cpu_sequencer
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [17:0] instr;
    logic        alu_zero;
    logic        alu_carry;
    logic        mem_ack;
    logic [9:0]  pc;
    logic [17:0] ir;
    logic [2:0]  alu_op;
    logic        alu_src;
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_req;
    logic        mem_we;
    logic        zf;
    logic        cf;
    logic        halted;
    logic [2:0]  state;
    logic [15:0] retired;

    logic [17:0] imem [0:1023];
    int n_checks = 0;
    int n_fail = 0;

    localparam logic [17:0] I_NOP  = 18'h38000;
    localparam logic [17:0] I_HALT = 18'h3C000;
    localparam logic [17:0] I_ADDI = 18'h04005;
    localparam logic [17:0] I_BEQ  = 18'h2C155;
    localparam logic [17:0] I_LD   = 18'h20000;
    localparam logic [17:0] I_ST   = 18'h24000;
    localparam logic [17:0] I_BNE  = 18'h300AA;
    localparam logic [17:0] I_JMP  = 18'h283FF;

    cpu_sequencer #(.PC_RESET(10'd0)) dut (
        .clk(clk), .reset(reset), .run(run), .instr(instr),
        .alu_zero(alu_zero), .alu_carry(alu_carry), .mem_ack(mem_ack),
        .pc(pc), .ir(ir), .alu_op(alu_op), .alu_src(alu_src),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .mem_req(mem_req),
        .mem_we(mem_we), .zf(zf), .cf(cf), .halted(halted),
        .state(state), .retired(retired)
    );

    always #5 clk = ~clk;
    assign instr = imem[pc];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_sp(input string tag, input logic [2:0] exp_state, input logic [9:0] exp_pc);
        chk({tag, "_state"}, {29'd0, state}, {29'd0, exp_state});
        chk({tag, "_pc"}, {22'd0, pc}, {22'd0, exp_pc});
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) imem[i] = I_NOP;
        imem[2]      = I_ADDI;
        imem[3]      = I_BEQ;
        imem[10'h155] = I_LD;
        imem[10'h156] = I_ST;
        imem[10'h157] = I_BNE;
        imem[10'h158] = I_JMP;

        reset = 1'b1; run = 1'b0; alu_zero = 1'b0; alu_carry = 1'b0; mem_ack = 1'b0;
        tick; tick;
        reset = 1'b0;
        chk_sp("rst", 3'd0, 10'd0);
        chk("rst_ir", {14'd0, ir}, 32'd0);
        chk("rst_retired", {16'd0, retired}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_flags", {30'd0, zf, cf}, 32'd0);
        chk("rst_enables", {27'd0, reg_write, mem_req, mem_we, mem_to_reg, alu_src}, 32'd0);

        // run low holds in FETCH
        tick;
        chk_sp("hold", 3'd0, 10'd0);
        run = 1'b1;

        // two NOPs
        tick; chk_sp("nop0_d", 3'd1, 10'd1);
        tick; chk_sp("nop0_e", 3'd2, 10'd1);
        tick; chk_sp("nop0_f", 3'd0, 10'd1);
        tick; chk_sp("nop1_d", 3'd1, 10'd2);
        tick; chk_sp("nop1_e", 3'd2, 10'd2);
        tick; chk_sp("nop1_f", 3'd0, 10'd2);
        chk("nop_retired", {16'd0, retired}, 32'd2);

        // ADDI with alu_zero=1
        alu_zero = 1'b1;
        tick; chk_sp("addi_d", 3'd1, 10'd3);
        chk("addi_d_src", {31'd0, alu_src}, 32'd0);
        chk("addi_d_rw", {31'd0, reg_write}, 32'd0);
        tick; chk_sp("addi_e", 3'd2, 10'd3);
        chk("addi_e_src", {31'd0, alu_src}, 32'd1);
        chk("addi_e_op", {29'd0, alu_op}, 32'd0);
        chk("addi_e_rw", {31'd0, reg_write}, 32'd0);
        tick; alu_zero = 1'b0;
        chk_sp("addi_wb", 3'd4, 10'd3);
        chk("addi_wb_zf", {31'd0, zf}, 32'd1);
        chk("addi_wb_cf", {31'd0, cf}, 32'd0);
        chk("addi_wb_rw", {31'd0, reg_write}, 32'd1);
        chk("addi_wb_m2r", {31'd0, mem_to_reg}, 32'd0);
        tick; chk_sp("addi_f", 3'd0, 10'd3);
        chk("addi_f_rw", {31'd0, reg_write}, 32'd0);
        chk("addi_f_op", {28'd0, alu_op, alu_src}, 32'd0);
        chk("addi_retired", {16'd0, retired}, 32'd3);

        // BEQ taken to 0x155
        tick; chk_sp("beq_d", 3'd1, 10'd4);
        tick; chk_sp("beq_e", 3'd2, 10'd4);
        tick; chk_sp("beq_f", 3'd0, 10'h155);
        chk("beq_retired", {16'd0, retired}, 32'd4);

        // LD with ack in the fourth MEM cycle
        tick; chk_sp("ld_d", 3'd1, 10'h156);
        tick; chk_sp("ld_e", 3'd2, 10'h156);
        chk("ld_e_req", {31'd0, mem_req}, 32'd0);
        tick; chk("ld_m1", {29'd0, state, mem_req, mem_we}, {29'd3, 2'b10});
        tick; chk("ld_m2", {29'd0, state, mem_req, mem_we}, {29'd3, 2'b10});
        tick; chk("ld_m3", {29'd0, state, mem_req, mem_we}, {29'd3, 2'b10});
        tick; chk("ld_m4", {29'd0, state, mem_req, mem_we}, {29'd3, 2'b10});
        mem_ack = 1'b1;
        tick; mem_ack = 1'b0;
        chk("ld_wb", {27'd0, state, mem_req, reg_write}, {27'd4, 2'b01});
        chk("ld_wb_m2r", {31'd0, mem_to_reg}, 32'd1);
        chk("ld_wb_retired", {16'd0, retired}, 32'd4);
        tick; chk_sp("ld_f", 3'd0, 10'h156);
        chk("ld_f_enables", {29'd0, reg_write, mem_to_reg, mem_req}, 32'd0);
        chk("ld_retired", {16'd0, retired}, 32'd5);

        // ST with immediate ack
        tick; chk_sp("st_d", 3'd1, 10'h157);
        tick; chk_sp("st_e", 3'd2, 10'h157);
        mem_ack = 1'b1;
        tick; chk("st_m", {28'd0, state, mem_req, mem_we, reg_write}, {28'd3, 3'b110});
        tick; mem_ack = 1'b0;
        chk_sp("st_f", 3'd0, 10'h157);
        chk("st_f_enables", {29'd0, mem_req, mem_we, reg_write}, 32'd0);
        chk("st_retired", {16'd0, retired}, 32'd6);

        // BNE untaken (zf=1)
        tick; tick; tick;
        chk_sp("bne_f", 3'd0, 10'h158);
        chk("bne_retired", {16'd0, retired}, 32'd7);

        // JMP 0x3FF, then NOP at 1023 wraps pc
        tick; tick; tick;
        chk_sp("jmp_f", 3'd0, 10'h3FF);
        tick; chk_sp("wrap_d", 3'd1, 10'd0);
        tick; tick;
        chk_sp("wrap_f", 3'd0, 10'd0);
        chk("wrap_retired", {16'd0, retired}, 32'd9);

        // HALT absorbs
        imem[0] = I_HALT;
        tick; chk_sp("halt_d", 3'd1, 10'd1);
        tick; chk_sp("halt_h", 3'd5, 10'd1);
        chk("halt_flag", {31'd0, halted}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            tick;
            chk("halt_hold_pc", {22'd0, pc}, 32'd1);
        end
        chk("halt_hold", {28'd0, state, halted}, {28'd5, 1'b1});
        chk("halt_retired", {16'd0, retired}, 32'd9);

        reset = 1'b1;
        tick; reset = 1'b0;
        chk_sp("halt_rst", 3'd0, 10'd0);
        chk("halt_rst_flag", {31'd0, halted}, 32'd0);
        chk("halt_rst_flags", {30'd0, zf, cf}, 32'd0);

        // reset in the middle of a stalled LD
        imem[0] = I_LD;
        tick; tick; tick;
        chk("mid_m1", {28'd0, state, mem_req}, {28'd3, 1'b1});
        tick;
        chk("mid_m2", {28'd0, state, mem_req}, {28'd3, 1'b1});
        reset = 1'b1;
        tick; reset = 1'b0; run = 1'b0;
        chk("mid_rst", {28'd0, state, mem_req}, 32'd0);
        chk("mid_rst_retired", {16'd0, retired}, 32'd0);
        mem_ack = 1'b1;
        tick; tick; mem_ack = 1'b0;
        chk_sp("stray_ack", 3'd0, 10'd0);
        chk("stray_ack_en", {29'd0, mem_req, reg_write, mem_to_reg}, 32'd0);
        chk("stray_ack_retired", {16'd0, retired}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
